// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial stage feeding the downstream retiming flop
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  in_data holds a word to transmit
//   in_data   parallel word, captured on an in_valid/in_ready handshake
//   in_ready  block can accept a word this cycle
//   ser_d     registered serial bit (IDLE_LEVEL when ser_en=0)
//   ser_en    registered qualifier: ser_d carries a data bit
//   busy      state is not IDLE
//   done      one-cycle pulse on the last bit of a word
//   bit_cnt   index of the bit currently on ser_d, 0 when idle

module bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_d,
    output logic             ser_en,
    output logic             busy,
    output logic             done,
    output logic [4:0]       bit_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [3:0]       gap_cnt;
    logic             last_bit;
    logic             take;

    // The register holds the bits still to be emitted; the bit now on ser_d
    // has already been shifted out of it.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);
    assign take     = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                    end else if (take) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready is held low throughout reset.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (rst) begin
            in_ready = (state == IDLE) || ((GAP_CYCLES == 0) && last_bit);
        end
        busy = (state != IDLE);
        done = last_bit;
    end

    // Datapath: serial output, shift register, bit index and gap timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            ser_d     <= IDLE_LEVEL;
            ser_en    <= 1'b0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= 4'd0;
        end else if (take) begin
            // First bit goes straight to ser_d on the handshake edge.
            shift_reg <= shift_once(in_data);
            ser_d     <= first_bit(in_data);
            ser_en    <= 1'b1;
            bit_cnt   <= 5'd0;
        end else if (state == SHIFT && !last_bit) begin
            shift_reg <= shift_once(shift_reg);
            ser_d     <= first_bit(shift_reg);
            bit_cnt   <= bit_cnt + 5'd1;
        end else if (state == SHIFT) begin
            ser_d     <= IDLE_LEVEL;
            ser_en    <= 1'b0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= GAP_LOAD;
        end else if (state == GAP && gap_cnt != 4'd0) begin
            gap_cnt   <= gap_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench for bit_serializer (MSB/gap, LSB, back-to-back)

module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic       v    [3];
    logic [7:0] dd   [3];
    logic       rdy  [3];
    logic       sd   [3];
    logic       sen  [3];
    logic       bsy  [3];
    logic       dn   [3];
    logic [4:0] cnt  [3];

    int total = 0;
    int bad   = 0;

    // Expected entry: {done, bit_cnt[4:0], ser_d}
    logic [6:0] sb0[$];
    logic [6:0] sb1[$];
    logic [6:0] sb2[$];
    logic [6:0] e;
    int         done_seen [3];
    int         run2     = 0;
    int         max_run2 = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(dd[0]), .in_ready(rdy[0]),
        .ser_d(sd[0]), .ser_en(sen[0]), .busy(bsy[0]), .done(dn[0]), .bit_cnt(cnt[0])
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(dd[1]), .in_ready(rdy[1]),
        .ser_d(sd[1]), .ser_en(sen[1]), .busy(bsy[1]), .done(dn[1]), .bit_cnt(cnt[1])
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_b2b (
        .clk(clk), .rst(rst), .in_valid(v[2]), .in_data(dd[2]), .in_ready(rdy[2]),
        .ser_d(sd[2]), .ser_en(sen[2]), .busy(bsy[2]), .done(dn[2]), .bit_cnt(cnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void sb_push(input int id, input logic [6:0] ent);
        case (id)
            0:       sb0.push_back(ent);
            1:       sb1.push_back(ent);
            default: sb2.push_back(ent);
        endcase
    endfunction

    function automatic int sb_size(input int id);
        case (id)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic logic [6:0] sb_pop(input int id);
        case (id)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic void push_word(input int id, input logic [7:0] w, input bit msb);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            sb_push(id, {(i == 7), 5'(i), b});
        end
    endfunction

    // Present a word, wait (bounded) for in_ready, record expected bits at the handshake.
    task automatic send(input int id, input logic [7:0] w, input bit msb);
        int n;
        n = 0;
        @(negedge clk);
        v[id]  = 1'b1;
        dd[id] = w;
        while (!rdy[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[id]) check("ready_timeout", 32'd0, 32'd1);
        else push_word(id, w, msb);
        @(posedge clk);
        #1;
        v[id]  = 1'b0;
        dd[id] = 8'($urandom);
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bsy[id] && n < 60);
        check("idle_timeout", 32'(bsy[id]), 32'd0);
    endtask

    // Scoreboard monitor: every ser_en cycle must match the next expected bit.
    always @(negedge clk) begin
        if (rst) begin
            for (int id = 0; id < 3; id++) begin
                if (sen[id]) begin
                    if (sb_size(id) == 0) begin
                        check($sformatf("extra_bit%0d", id), 32'd1, 32'd0);
                    end else begin
                        e = sb_pop(id);
                        check($sformatf("ser_d%0d", id), 32'(sd[id]), 32'(e[0]));
                        check($sformatf("bit_cnt%0d", id), 32'(cnt[id]), 32'(e[5:1]));
                        check($sformatf("done%0d", id), 32'(dn[id]), 32'(e[6]));
                    end
                end else begin
                    check($sformatf("idle_d%0d", id), 32'(sd[id]), 32'd0);
                    check($sformatf("idle_done%0d", id), 32'(dn[id]), 32'd0);
                    check($sformatf("idle_cnt%0d", id), 32'(cnt[id]), 32'd0);
                end
                if (dn[id] === 1'b1) done_seen[id]++;
            end
            run2 = sen[2] ? run2 + 1 : 0;
            if (run2 > max_run2) max_run2 = run2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done_before;
        for (int i = 0; i < 3; i++) begin
            v[i]         = 1'b0;
            dd[i]        = 8'h00;
            done_seen[i] = 0;
        end

        // T1: reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(rdy[0]), 32'd0);
        check("rst_ser_en", 32'(sen[0]), 32'd0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(rdy[0]), 32'd1);
        check("rel_ser_d", 32'(sd[0]), 32'd0);
        check("rel_ser_en", 32'(sen[0]), 32'd0);
        check("rel_busy", 32'(bsy[0]), 32'd0);
        check("rel_bit_cnt", 32'(cnt[0]), 32'd0);

        // T2: 8'hA5 MSB-first, one gap cycle
        send(0, 8'hA5, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn[0] && n < 30);
        check("t2_done_seen", 32'(dn[0]), 32'd1);
        @(negedge clk);
        check("t2_gap_ser_en", 32'(sen[0]), 32'd0);
        check("t2_gap_busy", 32'(bsy[0]), 32'd1);
        check("t2_gap_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        check("t2_after_ready", 32'(rdy[0]), 32'd1);
        check("t2_after_busy", 32'(bsy[0]), 32'd0);

        for (int i = 0; i < 3; i++) begin
            send(0, 8'($urandom), 1'b1);
        end
        wait_idle(0);

        // T3: LSB-first
        send(1, 8'h01, 1'b0);
        send(1, 8'h96, 1'b0);
        wait_idle(1);

        // T4: back-to-back with no gap
        @(negedge clk);
        v[2]  = 1'b1;
        dd[2] = 8'hFF;
        check("t4_ready0", 32'(rdy[2]), 32'd1);
        push_word(2, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        dd[2] = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[2] && n < 50);
        check("t4_ready1", 32'(rdy[2]), 32'd1);
        push_word(2, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        v[2] = 1'b0;
        wait_idle(2);
        check("t4_run", 32'(max_run2), 32'd16);

        // T5: reset in the middle of 8'hC3
        done_before = done_seen[0];
        send(0, 8'hC3, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cnt[0] != 5'd3 && n < 30);
        check("t5_reach_bit3", 32'(cnt[0]), 32'd3);
        rst = 1'b0;
        #1;
        check("t5_ser_en", 32'(sen[0]), 32'd0);
        check("t5_ser_d", 32'(sd[0]), 32'd0);
        check("t5_busy", 32'(bsy[0]), 32'd0);
        check("t5_bit_cnt", 32'(cnt[0]), 32'd0);
        check("t5_ready", 32'(rdy[0]), 32'd0);
        check("t5_done", 32'(dn[0]), 32'd0);
        sb0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(0, 8'h3C, 1'b1);
        wait_idle(0);
        check("t5_done_count", 32'(done_seen[0] - done_before), 32'd1);

        // T6: backpressure with in_data churning while busy
        @(negedge clk);
        v[0]  = 1'b1;
        dd[0] = 8'h5A;
        check("t6_ready_idle", 32'(rdy[0]), 32'd1);
        push_word(0, 8'h5A, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t6_bp_ready", 32'(rdy[0]), 32'd0);
            check("t6_bp_busy", 32'(bsy[0]), 32'd1);
            dd[0] = 8'($urandom);
        end
        v[0] = 1'b0;
        wait_idle(0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb_size(0) + sb_size(1) + sb_size(2)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
